pe_array_sched_ctrl: RTL and testbench
======================================

// Module: pe_array_sched_ctrl
// PURPOSE
//   Parametrised PE-array sequencer for the token engine; drives per-PE enable/move matrices.
//   Owns a PREHEAT -> NORMAL -> DRAIN FSM with per-column fill counters and a tile move counter.
//   Masks the array to the active rows/cols and applies layer-type mapping (diagonal-only for DW).
//   Sits between token-engine FIFO control (pop/push strobes) and the ROWSxCOLS PE array.
// PARAMETERS
//   ROWS   32  PE array rows
//   COLS   32  PE array columns
//   LEN_W  16  width of tile_len_i and internal move counter
// PORTS
//   clk                 in   1          clock
//   rst_n               in   1          async active-low reset
//   start_i             in   1          begin tile; accepted only in IDLE
//   abort_i             in   1          sync abort to IDLE from any state
//   layer_type_i        in   2          pe_ctrl_pkg::layer_t; latched at accepted start
//   active_rows_i       in   $clog2(ROWS+1)  rows in use (1..ROWS); latched at start
//   active_cols_i       in   $clog2(COLS+1)  cols in use (1..COLS); latched at start
//   tile_len_i          in   LEN_W      NORMAL-phase move count; latched at start
//   ifmap_fifo_pop_i    in   COLS       per-column ifmap pop strobe
//   opsum_fifo_push_i   in   COLS       per-column opsum push strobe
//   pe_array_move_i     in   1          global array advance in NORMAL
//   pe_en_matrix_o      out  ROWS*COLS  PE enable; bit r*COLS+c
//   pe_move_matrix_o    out  ROWS*COLS  1 = PE captures/shifts this cycle; bit r*COLS+c
//   busy_o              out  1          state != IDLE
//   done_o              out  1          1-cycle pulse on DRAIN completion
//   state_o             out  2          current pe_ctrl_pkg::state_t
// BEHAVIOUR
//   Reset: state=IDLE; all counters, latched config, and every output = 0.
//   Mask M[r][c]: STD/PW/LIN -> r<rows && c<cols; DW -> r==c && r<rows && c<cols.
//   pe_en_matrix_o = M in PREHEAT/NORMAL/DRAIN, else 0. pe_move_matrix_o is always ANDed with M.
//   Outputs are combinational from registered state/config plus same-cycle strobes (0-cycle latency).
//   IDLE: start_i -> latch config; rows==0 or cols==0 -> DONE path: done_o pulses next cycle, stay IDLE.
//     Otherwise -> PREHEAT. start_i outside IDLE is ignored.
//   PREHEAT: per active column c, fill_cnt[c] += ifmap_fifo_pop_i[c] while fill_cnt[c] < rows.
//     move[r][c] = ifmap_fifo_pop_i[c] && fill_cnt[c] < rows (columns already full do not move).
//     All active columns full -> NORMAL if tile_len != 0, else DRAIN. Pops on inactive columns are ignored.
//   NORMAL: move[r][c] = pe_array_move_i. mv_cnt increments per move;
//     move with mv_cnt == tile_len-1 -> DRAIN, mv_cnt cleared.
//   DRAIN: move[r][c] = opsum_fifo_push_i[0]; drn_cnt counts col-0 pushes;
//     push with drn_cnt == rows-1 -> IDLE, done_o=1 that cycle+1 (registered pulse), counters cleared.
//   abort_i: highest priority; next state IDLE, counters cleared, no done_o.
//     abort and start in the same IDLE cycle -> abort wins, start dropped.
//   Config inputs changing mid-tile have no effect. Counters never wrap (bounded by compare).
//   state encoding: IDLE=0, PREHEAT=1, NORMAL=2, DRAIN=3.
// STRUCTURE
//   pe_ctrl_pkg: state_t enum, layer_t enum (STD=0, DW=1, PW=2, LIN=3), idx(r,c) function.
//   Sub-module pe_mask_gen (combinational, ROWS/COLS params): latched rows/cols/layer -> M.
//   Top holds FSM, fill_cnt[COLS], mv_cnt, drn_cnt, done register.
// TESTING
//   Reset mid-NORMAL (rst_n low 1 cycle) -> state_o=0, all matrix bits 0, busy_o=0 immediately.
//   STD 4x4, tile_len=3: 4 pops on all cols -> NORMAL; 3 moves -> DRAIN; 4 pushes -> done_o 1 pulse;
//     en bits set exactly for r,c<4.
//   DW rows=cols=8: en/move only on bits r*32+r for r<8; all other bits 0 in every phase.
//   PREHEAT uneven pops (col0 popped 4x early, others 4x later) -> col0 move stops after 4th pop;
//     NORMAL entered the cycle after last col fills.
//   tile_len=0 -> PREHEAT goes straight to DRAIN; rows=0 at start -> done_o pulse, never busy.
//   abort_i asserted with start_i in IDLE, and mid-DRAIN -> IDLE, no done_o, counters cleared on next tile.

Source files
------------

// File: rtl/pe_array_sched_ctrl_pkg.sv
// pe_ctrl_pkg: shared types for the PE-array sequencer.
//   state_t : sequencer state, encoding visible on state_o
//   layer_t : layer-type mapping selector
//   idx     : flat bit position of PE (r, c) in a ROWS*COLS matrix
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREHEAT = 2'd1,
    ST_NORMAL  = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    LT_STD = 2'd0,
    LT_DW  = 2'd1,
    LT_PW  = 2'd2,
    LT_LIN = 2'd3
  } layer_t;

  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned ncols);
    return r * ncols + c;
  endfunction

endpackage

// File: rtl/pe_array_sched_ctrl_if.sv
// pe_array_sched_ctrl_if: token-engine strobes in, PE-array matrices out.
//   ifmap_fifo_pop_i   per-column ifmap pop strobe
//   opsum_fifo_push_i  per-column opsum push strobe (column 0 paces DRAIN)
//   pe_array_move_i    global array advance during NORMAL
//   pe_en_matrix_o     PE enable, bit r*COLS+c
//   pe_move_matrix_o   PE capture/shift, bit r*COLS+c
// master = token engine side, slave = sequencer.
interface pe_array_sched_ctrl_if #(
  parameter int ROWS = 32,
  parameter int COLS = 32
);
  logic [COLS-1:0]      ifmap_fifo_pop_i;
  logic [COLS-1:0]      opsum_fifo_push_i;
  logic                 pe_array_move_i;
  logic [ROWS*COLS-1:0] pe_en_matrix_o;
  logic [ROWS*COLS-1:0] pe_move_matrix_o;

  modport master (
    output ifmap_fifo_pop_i, opsum_fifo_push_i, pe_array_move_i,
    input  pe_en_matrix_o, pe_move_matrix_o
  );

  modport slave (
    input  ifmap_fifo_pop_i, opsum_fifo_push_i, pe_array_move_i,
    output pe_en_matrix_o, pe_move_matrix_o
  );
endinterface

// File: rtl/pe_array_sched_ctrl_mask_gen.sv
// pe_mask_gen: combinational active-region mask for the PE array.
//   rows, cols : latched active extent
//   layer      : latched layer type; DW keeps only the diagonal
//   mask       : 1 = PE (r, c) participates, bit r*COLS+c
module pe_mask_gen
  import pe_ctrl_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int COLS = 32,
  localparam int RW = $clog2(ROWS + 1),
  localparam int CW = $clog2(COLS + 1)
) (
  input  logic [RW-1:0]        rows,
  input  logic [CW-1:0]        cols,
  input  layer_t               layer,
  output logic [ROWS*COLS-1:0] mask
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign mask[idx(r, c, COLS)] = (RW'(r) < rows) && (CW'(c) < cols) &&
                                     ((layer != LT_DW) || (r == c));
    end
  end

endmodule

// File: rtl/pe_array_sched_ctrl.sv
// pe_array_sched_ctrl: PE-array sequencer for the token engine.
//   clk, rst_n           clock, async active-low reset
//   start_i, abort_i     tile start (IDLE only), abort to IDLE (highest priority)
//   layer_type_i, active_rows_i, active_cols_i, tile_len_i   tile config, latched at start
//   arr                  strobes in / enable+move matrices out
//   busy_o, done_o       not idle; 1-cycle pulse after DRAIN completes
//   state_o              current state
//
// state   | meaning
// IDLE    | waiting for start_i
// PREHEAT | filling each active column with `rows` ifmap pops
// NORMAL  | counting tile_len array moves
// DRAIN   | counting `rows` column-0 opsum pushes
module pe_array_sched_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int ROWS  = 32,
  parameter int COLS  = 32,
  parameter int LEN_W = 16,
  localparam int RW = $clog2(ROWS + 1),
  localparam int CW = $clog2(COLS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  layer_t                 layer_type_i,
  input  logic [RW-1:0]          active_rows_i,
  input  logic [CW-1:0]          active_cols_i,
  input  logic [LEN_W-1:0]       tile_len_i,
  pe_array_sched_ctrl_if.slave   arr,
  output logic                   busy_o,
  output logic                   done_o,
  output state_t                 state_o
);

  state_t               state_q;
  layer_t               layer_q;
  logic [RW-1:0]        rows_q;
  logic [CW-1:0]        cols_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     mv_cnt;
  logic [RW-1:0]        drn_cnt;
  logic                 done_q;
  logic [ROWS*COLS-1:0] mask;
  logic [COLS-1:0]      col_pop;
  logic [COLS-1:0]      col_full_nxt;
  logic [COLS-1:0]      move_col;
  logic                 fill_clr;
  logic                 push0;
  logic                 unused_push;

  assign push0       = arr.opsum_fifo_push_i[0];
  assign unused_push = ^arr.opsum_fifo_push_i[COLS-1:1];

  pe_mask_gen #(.ROWS(ROWS), .COLS(COLS)) u_mask (
    .rows  (rows_q),
    .cols  (cols_q),
    .layer (layer_q),
    .mask  (mask)
  );

  // Fill counters only live during PREHEAT; holding them clear elsewhere
  // means every new tile starts from zero without extra bookkeeping.
  assign fill_clr = abort_i || (state_q != ST_PREHEAT);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [RW-1:0] fill_cnt;
    logic          col_act;

    assign col_act         = (CW'(c) < cols_q);
    assign col_pop[c]      = arr.ifmap_fifo_pop_i[c] && col_act && (fill_cnt < rows_q);
    // Looks one pop ahead so NORMAL follows the edge that fills the last column.
    assign col_full_nxt[c] = !col_act || ((fill_cnt + RW'(col_pop[c])) >= rows_q);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          fill_cnt <= '0;
      else if (fill_clr)   fill_cnt <= '0;
      else if (col_pop[c]) fill_cnt <= fill_cnt + RW'(1);
    end
  end

  always_comb begin
    move_col = '0;
    case (state_q)
      ST_PREHEAT: move_col = col_pop;
      ST_NORMAL:  move_col = {COLS{arr.pe_array_move_i}};
      ST_DRAIN:   move_col = {COLS{push0}};
      default:    move_col = '0;
    endcase
  end

  assign arr.pe_en_matrix_o   = (state_q != ST_IDLE) ? mask : '0;
  assign arr.pe_move_matrix_o = mask & {ROWS{move_col}};
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      layer_q <= LT_STD;
      rows_q  <= '0;
      cols_q  <= '0;
      len_q   <= '0;
      mv_cnt  <= '0;
      drn_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q <= ST_IDLE;
        mv_cnt  <= '0;
        drn_cnt <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              layer_q <= layer_type_i;
              rows_q  <= active_rows_i;
              cols_q  <= active_cols_i;
              len_q   <= tile_len_i;
              mv_cnt  <= '0;
              drn_cnt <= '0;
              // An empty array has nothing to sequence: report done directly.
              if ((active_rows_i == '0) || (active_cols_i == '0)) done_q  <= 1'b1;
              else                                                  state_q <= ST_PREHEAT;
            end
          end
          ST_PREHEAT: begin
            if (&col_full_nxt) state_q <= (len_q != '0) ? ST_NORMAL : ST_DRAIN;
          end
          ST_NORMAL: begin
            if (arr.pe_array_move_i) begin
              if (mv_cnt == len_q - LEN_W'(1)) begin
                state_q <= ST_DRAIN;
                mv_cnt  <= '0;
              end else begin
                mv_cnt  <= mv_cnt + LEN_W'(1);
              end
            end
          end
          ST_DRAIN: begin
            if (push0) begin
              if (drn_cnt == rows_q - RW'(1)) begin
                state_q <= ST_IDLE;
                drn_cnt <= '0;
                done_q  <= 1'b1;
              end else begin
                drn_cnt <= drn_cnt + RW'(1);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pe_array_sched_ctrl.sv
// Directed bench for pe_array_sched_ctrl (32x32, LEN_W=16).
module tb_pe_array_sched_ctrl;
  import pe_ctrl_pkg::*;

  localparam int ROWS = 32;
  localparam int COLS = 32;
  localparam int LEN_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  layer_t      layer_type_i = LT_STD;
  logic [5:0]  active_rows_i = '0;
  logic [5:0]  active_cols_i = '0;
  logic [15:0] tile_len_i = '0;
  logic        busy_o;
  logic        done_o;
  state_t      state_o;

  int nvec = 0;
  int nerr = 0;

  pe_array_sched_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) arr_if ();

  pe_array_sched_ctrl #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .layer_type_i  (layer_type_i),
    .active_rows_i (active_rows_i),
    .active_cols_i (active_cols_i),
    .tile_len_i    (tile_len_i),
    .arr           (arr_if),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [1023:0] exp_mask(input int rows, input int cols, input bit dw);
    logic [1023:0] m;
    m = '0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        if (r < rows && c < cols && (!dw || r == c)) m[r*32 + c] = 1'b1;
    return m;
  endfunction

  function automatic logic [1023:0] col_rep(input logic [31:0] v);
    logic [1023:0] m;
    for (int r = 0; r < 32; r++) m[r*32 +: 32] = v;
    return m;
  endfunction

  function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
    for (int i = 0; i < 1024; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 0; abort_i = 0;
    arr_if.ifmap_fifo_pop_i = '0;
    arr_if.opsum_fifo_push_i = '0;
    arr_if.pe_array_move_i = 1'b0;
  endtask

  // Config inputs are scrambled right after acceptance; the DUT must keep the latched copy.
  task automatic do_start(input layer_t lt, input int rows, input int cols, input int len);
    start_i = 1; layer_type_i = lt;
    active_rows_i = 6'(rows); active_cols_i = 6'(cols); tile_len_i = 16'(len);
    cyc();
    start_i = 0; layer_type_i = LT_STD;
    active_rows_i = 6'd31; active_cols_i = 6'd31; tile_len_i = 16'd7;
  endtask

  task automatic run_pops(input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) begin arr_if.ifmap_fifo_pop_i = v; cyc(); end
    arr_if.ifmap_fifo_pop_i = '0;
  endtask

  task automatic run_moves(input int n);
    for (int i = 0; i < n; i++) begin arr_if.pe_array_move_i = 1'b1; cyc(); end
    arr_if.pe_array_move_i = 1'b0;
  endtask

  task automatic run_pushes(input int n);
    for (int i = 0; i < n; i++) begin arr_if.opsum_fifo_push_i = 32'h1; cyc(); end
    arr_if.opsum_fifo_push_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    cyc(); cyc();
    nvec++; if ({state_o, busy_o, done_o} !== 4'b0000) begin nerr++;
      $display("FAIL reset_ctrl: got state/busy/done=%b want 0000", {state_o, busy_o, done_o}); end
    nvec++; if ({arr_if.pe_en_matrix_o, arr_if.pe_move_matrix_o} !== '0) begin nerr++;
      $display("FAIL reset_matrix: got en bit %0d / move nonzero, want all 0", first_diff(arr_if.pe_en_matrix_o, '0)); end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_std();
    logic [1023:0] exp;
    exp = exp_mask(4, 4, 0);
    do_start(LT_STD, 4, 4, 3);
    #2;
    nvec++; if (state_o !== ST_PREHEAT) begin nerr++; $display("FAIL std_preheat: got %0d want 1", state_o); end
    nvec++; if (arr_if.pe_en_matrix_o !== exp) begin nerr++;
      $display("FAIL std_en: bit %0d got %b want %b", first_diff(arr_if.pe_en_matrix_o, exp),
               arr_if.pe_en_matrix_o[first_diff(arr_if.pe_en_matrix_o, exp)], exp[first_diff(arr_if.pe_en_matrix_o, exp)]); end
    for (int i = 0; i < 4; i++) begin
      arr_if.ifmap_fifo_pop_i = 32'hFFFF_FFFF;
      #2;
      nvec++; if (arr_if.pe_move_matrix_o !== exp) begin nerr++;
        $display("FAIL std_pop_move%0d: first diff bit %0d", i, first_diff(arr_if.pe_move_matrix_o, exp)); end
      cyc();
    end
    arr_if.ifmap_fifo_pop_i = '0;
    #2;
    nvec++; if (state_o !== ST_NORMAL) begin nerr++; $display("FAIL std_normal: got %0d want 2", state_o); end
    nvec++; if (arr_if.pe_move_matrix_o !== '0) begin nerr++;
      $display("FAIL std_idle_move: first set bit %0d want none", first_diff(arr_if.pe_move_matrix_o, '0)); end
    for (int i = 0; i < 3; i++) begin
      arr_if.pe_array_move_i = 1'b1;
      #2;
      nvec++; if ({state_o, (arr_if.pe_move_matrix_o === exp)} !== {ST_NORMAL, 1'b1}) begin nerr++;
        $display("FAIL std_move%0d: got state %0d match %b want 2 1", i, state_o, arr_if.pe_move_matrix_o === exp); end
      cyc();
    end
    arr_if.pe_array_move_i = 1'b0;
    arr_if.opsum_fifo_push_i = 32'hE;
    #2;
    nvec++; if ({state_o, busy_o} !== {ST_DRAIN, 1'b1}) begin nerr++;
      $display("FAIL std_drain: got state %0d busy %b want 3 1", state_o, busy_o); end
    nvec++; if (arr_if.pe_move_matrix_o !== '0) begin nerr++;
      $display("FAIL std_push_other_col: first set bit %0d want none", first_diff(arr_if.pe_move_matrix_o, '0)); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      arr_if.opsum_fifo_push_i = 32'h1;
      #2;
      nvec++; if ({done_o, state_o, (arr_if.pe_move_matrix_o === exp)} !== {1'b0, ST_DRAIN, 1'b1}) begin nerr++;
        $display("FAIL std_push%0d: got done %b state %0d match %b want 0 3 1", i, done_o, state_o,
                 arr_if.pe_move_matrix_o === exp); end
      cyc();
    end
    arr_if.opsum_fifo_push_i = '0;
    #2;
    nvec++; if ({state_o, busy_o, done_o} !== {ST_IDLE, 1'b0, 1'b1}) begin nerr++;
      $display("FAIL std_done: got state/busy/done=%b want 0001", {state_o, busy_o, done_o}); end
    cyc(); #2;
    nvec++; if (done_o !== 1'b0) begin nerr++; $display("FAIL std_done_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_dw();
    logic [1023:0] exp;
    exp = exp_mask(8, 8, 1);
    do_start(LT_DW, 8, 8, 1);
    #2;
    nvec++; if (arr_if.pe_en_matrix_o !== exp) begin nerr++;
      $display("FAIL dw_en_preheat: first diff bit %0d", first_diff(arr_if.pe_en_matrix_o, exp)); end
    for (int i = 0; i < 8; i++) begin
      arr_if.ifmap_fifo_pop_i = 32'hFFFF_FFFF;
      #2;
      if (i == 0 || i == 7) begin
        nvec++; if (arr_if.pe_move_matrix_o !== exp) begin nerr++;
          $display("FAIL dw_pop_move%0d: first diff bit %0d", i, first_diff(arr_if.pe_move_matrix_o, exp)); end
      end
      cyc();
    end
    arr_if.ifmap_fifo_pop_i = '0;
    arr_if.pe_array_move_i = 1'b1;
    #2;
    nvec++; if ({state_o, (arr_if.pe_en_matrix_o === exp), (arr_if.pe_move_matrix_o === exp)} !== {ST_NORMAL, 2'b11}) begin nerr++;
      $display("FAIL dw_normal: got state %0d en/move match %b%b want 2 11", state_o,
               arr_if.pe_en_matrix_o === exp, arr_if.pe_move_matrix_o === exp); end
    cyc();
    arr_if.pe_array_move_i = 1'b0;
    arr_if.opsum_fifo_push_i = 32'hFFFF_FFFF;
    #2;
    nvec++; if ({state_o, (arr_if.pe_move_matrix_o === exp)} !== {ST_DRAIN, 1'b1}) begin nerr++;
      $display("FAIL dw_drain_move: got state %0d match %b want 3 1", state_o, arr_if.pe_move_matrix_o === exp); end
    for (int i = 0; i < 8; i++) cyc();
    arr_if.opsum_fifo_push_i = '0;
    #2;
    nvec++; if ({state_o, done_o, (arr_if.pe_en_matrix_o === '0)} !== {ST_IDLE, 2'b11}) begin nerr++;
      $display("FAIL dw_done: got state %0d done %b en_zero %b want 0 1 1", state_o, done_o, arr_if.pe_en_matrix_o === '0); end
    cyc();
  endtask

  task automatic test_uneven();
    logic [1023:0] exp;
    exp = exp_mask(4, 4, 0);
    do_start(LT_STD, 4, 4, 2);
    for (int i = 0; i < 4; i++) begin
      arr_if.ifmap_fifo_pop_i = 32'h1;
      #2;
      nvec++; if (arr_if.pe_move_matrix_o !== (exp & col_rep(32'h1))) begin nerr++;
        $display("FAIL uneven_col0_%0d: first diff bit %0d", i, first_diff(arr_if.pe_move_matrix_o, exp & col_rep(32'h1))); end
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      arr_if.ifmap_fifo_pop_i = 32'hF;
      #2;
      nvec++; if ({state_o, (arr_if.pe_move_matrix_o === (exp & col_rep(32'hE)))} !== {ST_PREHEAT, 1'b1}) begin nerr++;
        $display("FAIL uneven_rest_%0d: got state %0d match %b want 1 1 (col0 must not move)", i, state_o,
                 arr_if.pe_move_matrix_o === (exp & col_rep(32'hE))); end
      cyc();
    end
    arr_if.ifmap_fifo_pop_i = '0;
    #2;
    nvec++; if (state_o !== ST_NORMAL) begin nerr++; $display("FAIL uneven_normal: got %0d want 2", state_o); end
    abort_i = 1; cyc(); abort_i = 0; #2;
    nvec++; if ({state_o, done_o} !== {ST_IDLE, 1'b0}) begin nerr++;
      $display("FAIL uneven_abort: got state %0d done %b want 0 0", state_o, done_o); end
    cyc();
  endtask

  task automatic test_zero_cases();
    do_start(LT_STD, 2, 3, 0);
    run_pops(2, 32'hFFFF_FFFF);
    #2;
    nvec++; if (state_o !== ST_DRAIN) begin nerr++; $display("FAIL len0_drain: got %0d want 3", state_o); end
    run_pushes(2);
    #2;
    nvec++; if ({state_o, done_o} !== {ST_IDLE, 1'b1}) begin nerr++;
      $display("FAIL len0_done: got state %0d done %b want 0 1", state_o, done_o); end
    cyc();
    do_start(LT_STD, 0, 4, 5);
    #2;
    nvec++; if ({state_o, busy_o, done_o} !== {ST_IDLE, 1'b0, 1'b1}) begin nerr++;
      $display("FAIL rows0_done: got state/busy/done=%b want 0001", {state_o, busy_o, done_o}); end
    cyc(); #2;
    nvec++; if ({busy_o, done_o} !== 2'b00) begin nerr++;
      $display("FAIL rows0_after: got busy/done=%b want 00", {busy_o, done_o}); end
  endtask

  task automatic test_abort();
    abort_i = 1;
    do_start(LT_STD, 4, 4, 1);
    abort_i = 0;
    #2;
    nvec++; if ({state_o, busy_o, done_o} !== {ST_IDLE, 1'b0, 1'b0}) begin nerr++;
      $display("FAIL abort_start: got state/busy/done=%b want 0000", {state_o, busy_o, done_o}); end
    do_start(LT_STD, 4, 4, 1);
    run_pops(4, 32'hF);
    run_moves(1);
    run_pushes(2);
    #2;
    nvec++; if (state_o !== ST_DRAIN) begin nerr++; $display("FAIL abort_pre_drain: got %0d want 3", state_o); end
    abort_i = 1; cyc(); abort_i = 0; #2;
    nvec++; if ({state_o, done_o} !== {ST_IDLE, 1'b0}) begin nerr++;
      $display("FAIL abort_drain: got state %0d done %b want 0 0", state_o, done_o); end
    cyc();
    do_start(LT_STD, 4, 4, 1);
    run_pops(4, 32'hF);
    run_moves(1);
    run_pushes(3);
    #2;
    nvec++; if ({state_o, done_o} !== {ST_DRAIN, 1'b0}) begin nerr++;
      $display("FAIL abort_cleared_cnt: got state %0d done %b want 3 0", state_o, done_o); end
    run_pushes(1);
    #2;
    nvec++; if ({state_o, done_o} !== {ST_IDLE, 1'b1}) begin nerr++;
      $display("FAIL abort_next_tile_done: got state %0d done %b want 0 1", state_o, done_o); end
    cyc();
  endtask

  task automatic test_reset_mid_normal();
    do_start(LT_STD, 4, 4, 3);
    run_pops(4, 32'hF);
    arr_if.pe_array_move_i = 1'b1;
    cyc();
    rst_n = 0;
    #1;
    nvec++; if ({state_o, busy_o} !== {ST_IDLE, 1'b0}) begin nerr++;
      $display("FAIL rst_mid_ctrl: got state %0d busy %b want 0 0", state_o, busy_o); end
    nvec++; if ({arr_if.pe_en_matrix_o, arr_if.pe_move_matrix_o} !== '0) begin nerr++;
      $display("FAIL rst_mid_matrix: en diff bit %0d move diff bit %0d want all 0",
               first_diff(arr_if.pe_en_matrix_o, '0), first_diff(arr_if.pe_move_matrix_o, '0)); end
    cyc();
    rst_n = 1;
    arr_if.pe_array_move_i = 1'b0;
    cyc(); #2;
    nvec++; if (state_o !== ST_IDLE) begin nerr++; $display("FAIL rst_mid_after: got %0d want 0", state_o); end
  endtask

  initial begin
    test_reset();
    test_std();
    test_dw();
    test_uneven();
    test_zero_cases();
    test_abort();
    test_reset_mid_normal();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
